// File: rtl/alu_seq.sv
// Single-clock phase-sequenced ALU: runs one decoded instruction as a short series of
// phase results, each handed to the consumer under a result_valid/result_ack handshake.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = 1,
  parameter int STACK_DOWN = 0,
  parameter int CALL_LEN   = 5,
  parameter int IMM8_SEXT  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      ope,
  input  logic [3:0]       num_of_ope,
  input  logic [WIDTH-1:0] registor_in,
  input  logic             result_ack,
  output logic             busy,
  output logic [WIDTH-1:0] alu_result_bus,
  output logic             result_valid,
  output logic [1:0]       phase,
  output logic             done,
  output logic             illegal
);

  localparam logic [7:0] OP_PUSH_EBP = 8'h55;
  localparam logic [7:0] OP_MOV      = 8'h89;
  localparam logic [7:0] OP_MOV_IMM  = 8'hb8;
  localparam logic [7:0] OP_POP_EBP  = 8'h5d;
  localparam logic [7:0] OP_RET      = 8'hc3;
  localparam logic [7:0] OP_CALL     = 8'he2;
  localparam logic [7:0] OP_PUSH_IMM = 8'h6a;

  localparam logic [WIDTH-1:0] STEP     = WIDTH'(STACK_STEP);
  localparam logic [WIDTH-1:0] CALL_SUB = WIDTH'(CALL_LEN);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, FIN} state_t;

  state_t      state;
  logic [31:0] ope_q;
  logic [3:0]  num_q;

  logic [7:0]       opcode;
  logic [WIDTH-1:0] push_val;
  logic [WIDTH-1:0] pop_val;
  logic [WIDTH-1:0] imm24;
  logic [WIDTH-1:0] rel;
  logic [WIDTH-1:0] imm8;
  logic [WIDTH-1:0] call_next;
  logic             legal;
  logic [1:0]       last_phase;
  logic [WIDTH-1:0] phase_value;

  assign opcode = ope_q[31:24];

  // Immediate fields are little-endian byte streams packed into the low bytes of the word.
  always_comb begin
    push_val  = (STACK_DOWN == 0) ? registor_in + STEP : registor_in - STEP;
    pop_val   = (STACK_DOWN == 0) ? registor_in - STEP : registor_in + STEP;
    imm24     = WIDTH'({ope_q[7:0], ope_q[15:8], ope_q[23:16]});
    rel       = WIDTH'($signed({ope_q[7:0], ope_q[15:8]}));
    imm8      = (IMM8_SEXT != 0) ? WIDTH'($signed(ope_q[23:16])) : WIDTH'(ope_q[23:16]);
    call_next = registor_in + WIDTH'(num_q);
  end

  always_comb begin
    legal       = 1'b1;
    last_phase  = 2'd0;
    phase_value = '0;
    case (opcode)
      OP_PUSH_EBP: begin
        last_phase  = 2'd1;
        phase_value = (phase == 2'd0) ? push_val : registor_in;
      end
      OP_MOV: begin
        phase_value = registor_in;
      end
      OP_MOV_IMM: begin
        phase_value = imm24;
      end
      OP_POP_EBP: begin
        last_phase  = 2'd1;
        phase_value = (phase == 2'd0) ? registor_in : pop_val;
      end
      OP_RET: begin
        last_phase  = 2'd1;
        phase_value = pop_val;
      end
      OP_CALL: begin
        last_phase = 2'd2;
        case (phase)
          2'd0:    phase_value = push_val;
          2'd1:    phase_value = call_next;
          default: phase_value = call_next + rel - CALL_SUB;
        endcase
      end
      OP_PUSH_IMM: begin
        last_phase  = 2'd1;
        phase_value = (phase == 2'd0) ? push_val : imm8;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // done is raised on entry to FIN so it appears one cycle after the final ack,
  // while busy is still high; busy falls as the sequencer re-enters IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      ope_q          <= '0;
      num_q          <= '0;
      busy           <= 1'b0;
      alu_result_bus <= '0;
      result_valid   <= 1'b0;
      phase          <= 2'd0;
      done           <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ope_q <= ope;
            num_q <= num_of_ope;
            phase <= 2'd0;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (legal) begin
            alu_result_bus <= phase_value;
            result_valid   <= 1'b1;
            state          <= WAIT;
          end else begin
            illegal <= 1'b1;
            done    <= 1'b1;
            state   <= FIN;
          end
        end
        WAIT: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            if (phase == last_phase) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              phase <= phase + 2'd1;
              state <= EXEC;
            end
          end
        end
        FIN: begin
          phase <= 2'd0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes reference phase results into a queue
// and a negedge monitor pops and compares each newly presented result.
module tb_alu_seq;

  localparam int W          = 32;
  localparam int STACK_STEP = 1;
  localparam int STACK_DOWN = 0;
  localparam int CALL_LEN   = 5;
  localparam int IMM8_SEXT  = 1;

  logic         clock;
  logic         reset;
  logic         start;
  logic [31:0]  ope;
  logic [3:0]   num_of_ope;
  logic [W-1:0] registor_in;
  logic         result_ack;
  logic         busy;
  logic [W-1:0] alu_result_bus;
  logic         result_valid;
  logic [1:0]   phase;
  logic         done;
  logic         illegal;

  alu_seq #(
    .WIDTH(W), .STACK_STEP(STACK_STEP), .STACK_DOWN(STACK_DOWN),
    .CALL_LEN(CALL_LEN), .IMM8_SEXT(IMM8_SEXT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .ope(ope), .num_of_ope(num_of_ope),
    .registor_in(registor_in), .result_ack(result_ack), .busy(busy),
    .alu_result_bus(alu_result_bus), .result_valid(result_valid), .phase(phase),
    .done(done), .illegal(illegal)
  );

  typedef struct {
    logic [W-1:0] value;
    int           ph;
  } exp_t;

  exp_t         exp_q[$];
  int           n_compared;
  int           n_mismatched;
  logic [W-1:0] last_bus;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int num_phases(input logic [7:0] op);
    case (op)
      8'h55, 8'h5d, 8'hc3, 8'h6a: return 2;
      8'h89, 8'hb8:               return 1;
      8'he2:                      return 3;
      default:                    return 0;
    endcase
  endfunction

  // Reference result computed with plain signed integer arithmetic, then wrapped to W bits.
  function automatic logic [W-1:0] ref_result(input logic [31:0] o, input int ph,
                                                input logic [W-1:0] r, input logic [3:0] n);
    longint s, rv, rel, imm8, imm24, res;
    s     = (STACK_DOWN == 0) ? longint'(STACK_STEP) : -longint'(STACK_STEP);
    rv    = longint'(r);
    rel   = longint'({o[7:0], o[15:8]});
    if (rel >= 32768) rel = rel - 65536;
    imm8  = longint'(o[23:16]);
    if (IMM8_SEXT != 0 && imm8 >= 128) imm8 = imm8 - 256;
    imm24 = longint'(o[7:0]) * 65536 + longint'(o[15:8]) * 256 + longint'(o[23:16]);
    res   = 0;
    case (o[31:24])
      8'h55: res = (ph == 0) ? rv + s : rv;
      8'h89: res = rv;
      8'hb8: res = imm24;
      8'h5d: res = (ph == 0) ? rv : rv - s;
      8'hc3: res = rv - s;
      8'he2: res = (ph == 0) ? rv + s : (ph == 1) ? rv + n : rv + n + rel - CALL_LEN;
      8'h6a: res = (ph == 0) ? rv + s : imm8;
      default: res = 0;
    endcase
    return W'(res);
  endfunction

  always @(negedge clock) begin
    exp_t         e;
    logic         prev_valid;
    logic [W-1:0] held;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("result_value", alu_result_bus, e.value);
          check_output("result_phase", phase, e.ph);
        end
        held = alu_result_bus;
      end else if (result_valid) begin
        check_output("result_stable", alu_result_bus, held);
      end
      prev_valid = result_valid;
    end
  end

  task automatic wait_valid();
    int lat;
    lat = 0;
    while (!result_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check_output("valid_latency", lat, 1);
  endtask

  task automatic apply_stimulus(input logic [31:0] op, input logic [3:0] n,
                                input logic [W-1:0] r0, input logic [W-1:0] r1, input logic [W-1:0] r2,
                                input int ack_delay, input bit busy_poke, input bit done_start);
    logic [W-1:0] regs[3];
    int nph;
    int hold;
    regs = '{r0, r1, r2};
    nph  = num_phases(op[31:24]);
    for (int k = 0; k < nph; k++) begin
      exp_q.push_back('{value: ref_result(op, k, regs[k], n), ph: k});
      last_bus = ref_result(op, k, regs[k], n);
    end
    @(posedge clock); #1;
    start = 1'b1; ope = op; num_of_ope = n; registor_in = regs[0];
    @(posedge clock); #1;
    start = 1'b0; ope = $urandom; num_of_ope = 4'($urandom);
    check_output("busy_after_start", busy, 1);
    if (nph == 0) begin
      @(posedge clock); #1;
      check_output("illegal_pulse", illegal, 1);
      check_output("illegal_done", done, 1);
      check_output("illegal_no_valid", result_valid, 0);
      check_output("illegal_bus_kept", alu_result_bus, last_bus);
      @(posedge clock); #1;
      check_output("illegal_pulse_end", illegal, 0);
      check_output("illegal_idle_busy", busy, 0);
      return;
    end
    for (int k = 0; k < nph; k++) begin
      wait_valid();
      hold = (busy_poke && ack_delay == 0) ? 1 : ack_delay;
      for (int d = 0; d < hold; d++) begin
        if (busy_poke && d == 0) begin
          start = 1'b1; ope = 32'hb8ffffff;
        end
        @(posedge clock); #1;
        start = 1'b0;
      end
      result_ack  = 1'b1;
      registor_in = (k + 1 < nph) ? regs[k+1] : W'($urandom);
      @(posedge clock); #1;
      result_ack = 1'b0;
    end
    check_output("done_pulse", done, 1);
    check_output("busy_in_done", busy, 1);
    check_output("valid_low_in_done", result_valid, 0);
    if (done_start) begin
      start = 1'b1; ope = 32'h89000000;
    end
    @(posedge clock); #1;
    start = 1'b0;
    check_output("done_end", done, 0);
    check_output("busy_end", busy, 0);
    check_output("phase_end", phase, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_valid"}, result_valid, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_illegal"}, illegal, 0);
    check_output({tag, "_phase"}, phase, 0);
    check_output({tag, "_bus"}, alu_result_bus, 0);
  endtask

  initial begin
    logic [7:0]  op_tab[7];
    logic [31:0] rnd;
    logic [7:0]  op;
    int          sel;
    op_tab = '{8'h55, 8'h89, 8'hb8, 8'h5d, 8'hc3, 8'he2, 8'h6a};
    n_compared = 0; n_mismatched = 0; last_bus = '0;
    reset = 1'b1; start = 1'b0; ope = '0; num_of_ope = '0; registor_in = '0; result_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    apply_stimulus(32'h55000000, 4'd0, 32'h100, 32'h200, 32'h0, 0, 1'b0, 1'b0);
    apply_stimulus(32'he200eeff, 4'd5, 32'h40, 32'h40, 32'h40, 1, 1'b0, 1'b1);
    apply_stimulus(32'hb8123456, 4'd5, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    apply_stimulus(32'h5d000000, 4'd1, 32'h80, 32'h80, 32'h0, 2, 1'b0, 1'b0);
    apply_stimulus(32'h6af00000, 4'd2, 32'h10, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    apply_stimulus(32'h90000000, 4'd1, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    apply_stimulus(32'h55000000, 4'd1, 32'hffffffff, 32'h5, 32'h0, 10, 1'b1, 1'b0);
    apply_stimulus(32'h5d000000, 4'd1, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1);
    apply_stimulus(32'hc3000000, 4'd1, 32'h1000, 32'h2000, 32'h0, 3, 1'b1, 1'b0);
    apply_stimulus(32'h89abcdef, 4'd3, 32'hdeadbeef, 32'h0, 32'h0, 0, 1'b0, 1'b0);

    // Reset during the second phase of a call: the remaining phase must be discarded.
    exp_q.push_back('{value: ref_result(32'he2001000, 0, 32'h500, 4'd5), ph: 0});
    exp_q.push_back('{value: ref_result(32'he2001000, 1, 32'h600, 4'd5), ph: 1});
    @(posedge clock); #1;
    start = 1'b1; ope = 32'he2001000; num_of_ope = 4'd5; registor_in = 32'h500;
    @(posedge clock); #1;
    start = 1'b0;
    wait_valid();
    result_ack = 1'b1; registor_in = 32'h600;
    @(posedge clock); #1;
    result_ack = 1'b0;
    wait_valid();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    last_bus = '0;
    check_all_zero("mid_reset");
    apply_stimulus(32'he2000400, 4'd7, 32'h7000, 32'h7100, 32'h7200, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      rnd = $urandom;
      op  = (sel == 7) ? 8'($urandom) : op_tab[sel];
      apply_stimulus({op, rnd[23:0]}, 4'($urandom), $urandom, $urandom, $urandom,
                     $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    @(posedge clock); #1;
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
